// File: rtl/cl_fifo_rr_arbiter.sv
// cl_fifo_rr_arbiter
// Round-robin merge of N_REQ first-word-fall-through FIFO read sides onto a
// single FIFO write side. A grant is held for at most MAX_BURST words and is
// then rotated to the next requester. The data path is a pure mux from the
// granted source to the sink; only arbitration state is registered.

module cl_fifo_rr_arbiter #(
   parameter  int N_REQ     = 4,
   parameter  int DATA_W    = 32,
   parameter  int MAX_BURST = 8,
   localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic [N_REQ-1:0]          empty_i,
   input  logic [N_REQ*DATA_W-1:0]   read_data_i,
   output logic [N_REQ-1:0]          read_o,
   input  logic                      full_i,
   output logic                      write_o,
   output logic [DATA_W-1:0]         write_data_o,
   output logic [N_REQ-1:0]          grant_o,
   output logic [ID_W-1:0]           grant_id_o,
   output logic                      busy_o
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]        r_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [CNT_W-1:0]  r_burst_cnt;
   logic [N_REQ-1:0]  r_grant;
   logic [ID_W-1:0]   r_grant_id;

   logic [DATA_W-1:0] w_src_data [N_REQ];
   logic              w_pick_found;
   logic [ID_W-1:0]   w_pick_id;
   logic [N_REQ-1:0]  w_pick_onehot;
   logic              w_src_empty;
   logic              w_xfer;
   logic              w_last;
   logic [ID_W-1:0]   w_next_ptr;

   // Index base+offs wrapped into 0..N_REQ-1 (offs is always below N_REQ).
   function automatic logic [ID_W-1:0] f_wrap_idx(input logic [ID_W-1:0] base, input int offs);
      int v_sum;
      v_sum = int'(base) + offs;
      if (v_sum >= N_REQ) begin
         v_sum = v_sum - N_REQ;
      end else begin
         v_sum = v_sum;
      end
      return ID_W'(v_sum);
   endfunction

   // Split the flat source bus into one word per requester.
   for (genvar k = 0; k < N_REQ; k++) begin : g_src
      assign w_src_data[k] = read_data_i[k*DATA_W +: DATA_W];
   end

   // Find the first non-empty source starting at the round-robin pointer.
   always_comb begin
      w_pick_found  = 1'b0;
      w_pick_id     = '0;
      w_pick_onehot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!w_pick_found && !empty_i[f_wrap_idx(r_rr_ptr, i)]) begin
            w_pick_found = 1'b1;
            w_pick_id    = f_wrap_idx(r_rr_ptr, i);
         end else begin
            w_pick_found = w_pick_found;
         end
      end
      w_pick_onehot[w_pick_id] = 1'b1;
   end

   // Transfer qualification for the granted source and the rotation target.
   always_comb begin
      w_src_empty = empty_i[r_grant_id];
      w_xfer      = (r_state == S_GRANT) && !w_src_empty && !full_i;
      w_last      = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
      if (r_grant_id == ID_W'(N_REQ - 1)) begin
         w_next_ptr = '0;
      end else begin
         w_next_ptr = r_grant_id + ID_W'(1);
      end
   end

   // Arbitration FSM: one idle cycle to pick, then hold the grant for a burst.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_grant     <= '0;
         r_grant_id  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick_found) begin
                  r_state     <= S_GRANT;
                  r_grant_id  <= w_pick_id;
                  r_grant     <= w_pick_onehot;
                  r_burst_cnt <= '0;
               end else begin
                  r_grant     <= '0;
               end
            end
            S_GRANT: begin
               if (w_xfer && w_last) begin
                  // Last word of the burst leaves this cycle.
                  r_state     <= S_IDLE;
                  r_grant     <= '0;
                  r_rr_ptr    <= w_next_ptr;
                  r_burst_cnt <= '0;
               end else if (w_xfer) begin
                  r_burst_cnt <= r_burst_cnt + CNT_W'(1);
               end else if (w_src_empty) begin
                  // Source ran dry: give the slot to the next requester.
                  r_state     <= S_IDLE;
                  r_grant     <= '0;
                  r_rr_ptr    <= w_next_ptr;
                  r_burst_cnt <= '0;
               end else begin
                  // Sink full: hold the grant with the burst count frozen.
                  r_burst_cnt <= r_burst_cnt;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_grant     <= '0;
               r_burst_cnt <= '0;
            end
         endcase
      end
   end

   assign read_o       = w_xfer ? r_grant : '0;
   assign write_o      = w_xfer;
   assign write_data_o = w_src_data[r_grant_id];
   assign grant_o      = r_grant;
   assign grant_id_o   = r_grant_id;
   assign busy_o       = (r_state == S_GRANT);

endmodule

// File: tb/tb_cl_fifo_rr_arbiter.sv
// Testbench for cl_fifo_rr_arbiter: behavioural FWFT source FIFOs feed the
// arbiter, a negedge monitor scores every delivered word against per-source
// expected sequence numbers, and scenario tasks check grant timing.

module tb_cl_fifo_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int MB = 8;

   logic           clock_i = 1'b0;
   logic           reset_i;
   logic [N-1:0]   empty_i;
   logic [N*W-1:0] read_data_i;
   logic [N-1:0]   read_o;
   logic           full_i;
   logic           write_o;
   logic [W-1:0]   write_data_o;
   logic [N-1:0]   grant_o;
   logic [1:0]     grant_id_o;
   logic           busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] src_q [N][$];
   int           push_cnt [N];
   int           exp_seq  [N];

   cl_fifo_rr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .empty_i      (empty_i),
      .read_data_i  (read_data_i),
      .read_o       (read_o),
      .full_i       (full_i),
      .write_o      (write_o),
      .write_data_o (write_data_o),
      .grant_o      (grant_o),
      .grant_id_o   (grant_id_o),
      .busy_o       (busy_o)
   );

   // Free-running clock.
   always #5 clock_i = ~clock_i;

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) begin
         if (v[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   // Present every source FIFO head and empty flag to the DUT.
   task automatic refresh();
      for (int k = 0; k < N; k++) begin
         empty_i[k] = (src_q[k].size() == 0);
         read_data_i[k*W +: W] = (src_q[k].size() != 0) ? src_q[k][0] : 32'hDEAD_0000;
      end
   endtask

   // Append n tagged words {source, sequence} to source k.
   task automatic push_words(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         src_q[k].push_back({8'(k), 24'(push_cnt[k])});
         push_cnt[k]++;
      end
      refresh();
   endtask

   // Source FIFOs update just after the clock edge, using pops seen by the monitor.
   always @(posedge clock_i) begin
      #1;
      refresh();
   end

   // Scoreboard: every pop must be legal and carry the next word of its source.
   always @(negedge clock_i) begin : mon
      int k;
      if (write_o === 1'b1 || read_o !== '0) begin
         n_checks++;
         k = oh_idx(read_o);
         if (full_i === 1'b1 || write_o !== 1'b1 || read_o !== grant_o ||
             $countones(read_o) != 1 || k < 0 || src_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL pop_legal: write=%b read=%b grant=%b full=%b, required one-hot read==grant to a non-empty source, not full",
                     write_o, read_o, grant_o, full_i);
         end else begin
            n_checks++;
            if (write_data_o !== {8'(k), 24'(exp_seq[k])}) begin
               n_fail++;
               $display("FAIL data_src%0d: got %h expected %h", k, write_data_o, {8'(k), 24'(exp_seq[k])});
            end
            exp_seq[k]++;
            void'(src_q[k].pop_front());
         end
      end
   end

   task automatic do_reset();
      @(posedge clock_i); #2;
      reset_i = 1'b1;
      @(posedge clock_i); #2;
      reset_i = 1'b0;
   endtask

   // Let everything drain, then confirm each source delivered all its words.
   task automatic drain(input string tag);
      int cyc;
      bit pend;
      cyc = 0;
      pend = 1'b1;
      while (pend && cyc < 3000) begin
         @(negedge clock_i);
         cyc++;
         pend = (busy_o !== 1'b0);
         for (int k = 0; k < N; k++) if (src_q[k].size() != 0) pend = 1'b1;
      end
      n_checks++;
      if (pend) begin
         n_fail++;
         $display("FAIL %s_drain: still busy after %0d cycles, required idle", tag, cyc);
      end
      for (int k = 0; k < N; k++) begin
         n_checks++;
         if (exp_seq[k] != push_cnt[k]) begin
            n_fail++;
            $display("FAIL %s_count_src%0d: delivered %0d expected %0d", tag, k, exp_seq[k], push_cnt[k]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      n_checks++;
      if ({grant_o, grant_id_o, read_o, write_o, busy_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got grant=%b id=%0d read=%b write=%b busy=%b, required all 0",
                  grant_o, grant_id_o, read_o, write_o, busy_o);
      end
      @(posedge clock_i); #2;
      reset_i = 1'b0;
      @(negedge clock_i);
      n_checks++;
      if ({grant_o, read_o, write_o, busy_o} !== '0) begin
         n_fail++;
         $display("FAIL idle_outputs: got grant=%b read=%b write=%b busy=%b, required all 0",
                  grant_o, read_o, write_o, busy_o);
      end
   endtask

   task automatic test_single_source();
      logic [5:0] wr;
      @(posedge clock_i); #2;
      push_words(0, 3);
      for (int c = 0; c < 6; c++) begin
         @(negedge clock_i);
         wr[c] = write_o;
         if (c == 1) begin
            n_checks++;
            if (grant_o !== 4'b0001) begin
               n_fail++;
               $display("FAIL single_grant: got %b expected 0001", grant_o);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin
               n_fail++;
               $display("FAIL single_idle: got busy=%b grant=%b expected 0/0000", busy_o, grant_o);
            end
         end
      end
      n_checks++;
      if (wr !== 6'b001110) begin
         n_fail++;
         $display("FAIL single_write_pattern: got %b expected 001110", wr);
      end
      drain("single");
   endtask

   task automatic test_back_to_back();
      int tr[$];
      int run_src[$];
      int run_len[$];
      int gap[$];
      int cur_src, cur_len, cur_gap;
      do_reset();
      @(posedge clock_i); #2;
      for (int k = 0; k < N; k++) push_words(k, 20);
      for (int c = 0; c < 130; c++) begin
         @(negedge clock_i);
         tr.push_back((write_o === 1'b1) ? oh_idx(read_o) : -1);
      end
      cur_src = -1; cur_len = 0; cur_gap = 0;
      foreach (tr[i]) begin
         if (tr[i] >= 0) begin
            if (cur_len > 0 && tr[i] == cur_src && cur_gap == 0) begin
               cur_len++;
            end else begin
               if (cur_len > 0) begin
                  run_src.push_back(cur_src);
                  run_len.push_back(cur_len);
                  gap.push_back(cur_gap);
               end
               cur_src = tr[i];
               cur_len = 1;
               cur_gap = 0;
            end
         end else if (cur_len > 0) begin
            cur_gap++;
         end
      end
      if (cur_len > 0) begin
         run_src.push_back(cur_src);
         run_len.push_back(cur_len);
         gap.push_back(-1);
      end
      n_checks++;
      if (run_src.size() != 12) begin
         n_fail++;
         $display("FAIL b2b_runs: got %0d bursts expected 12", run_src.size());
      end else begin
         for (int r = 0; r < 12; r++) begin
            n_checks++;
            if (run_src[r] != r % 4 || run_len[r] != ((r < 8) ? 8 : 4)) begin
               n_fail++;
               $display("FAIL b2b_burst%0d: got src%0d x%0d expected src%0d x%0d",
                        r, run_src[r], run_len[r], r % 4, (r < 8) ? 8 : 4);
            end
            if (r < 8) begin
               n_checks++;
               if (gap[r] != 1) begin
                  n_fail++;
                  $display("FAIL b2b_bubble%0d: got %0d idle cycles expected 1", r, gap[r]);
               end
            end
         end
      end
      drain("b2b");
   endtask

   task automatic test_backpressure();
      int wcnt, more, cyc;
      do_reset();
      @(posedge clock_i); #2;
      push_words(1, 20);
      wcnt = 0; cyc = 0;
      while (wcnt < 3 && cyc < 20) begin
         @(negedge clock_i);
         cyc++;
         if (write_o === 1'b1) wcnt++;
      end
      @(posedge clock_i); #2;
      full_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock_i);
         n_checks++;
         if (write_o !== 1'b0 || read_o !== 4'b0000 || grant_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_cycle%0d: got write=%b read=%b grant=%b expected 0/0000/0010",
                     c, write_o, read_o, grant_o);
         end
      end
      @(posedge clock_i); #2;
      full_i = 1'b0;
      more = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock_i);
         if (grant_o !== 4'b0010) break;
         if (write_o === 1'b1) more++;
      end
      n_checks++;
      if (more != 5) begin
         n_fail++;
         $display("FAIL stall_resume: got %0d words after stall expected 5", more);
      end
      n_checks++;
      if (src_q[1].size() != 12) begin
         n_fail++;
         $display("FAIL stall_remaining: got %0d words left expected 12", src_q[1].size());
      end
      drain("stall");
   endtask

   task automatic test_rotation();
      int cnt2;
      logic [N-1:0] nxt;
      do_reset();
      @(posedge clock_i); #2;
      push_words(2, 3);
      cnt2 = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock_i);
         if (write_o === 1'b1 && read_o === 4'b0100) cnt2++;
         if (grant_o === 4'b0100) break;
      end
      @(posedge clock_i); #2;
      push_words(3, 2);
      push_words(0, 2);
      nxt = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock_i);
         if (write_o === 1'b1 && read_o === 4'b0100) cnt2++;
         if (grant_o !== 4'b0000 && grant_o !== 4'b0100) begin
            nxt = grant_o;
            break;
         end
      end
      n_checks++;
      if (cnt2 != 3) begin
         n_fail++;
         $display("FAIL rot_src2_words: got %0d expected 3", cnt2);
      end
      n_checks++;
      if (nxt !== 4'b1000) begin
         n_fail++;
         $display("FAIL rot_next_grant: got %b expected 1000", nxt);
      end
      drain("rot");
   endtask

   task automatic test_reset_mid_burst();
      int wcnt, cyc;
      do_reset();
      @(posedge clock_i); #2;
      push_words(1, 8);
      wcnt = 0; cyc = 0;
      while (wcnt < 3 && cyc < 20) begin
         @(negedge clock_i);
         cyc++;
         if (write_o === 1'b1) wcnt++;
      end
      @(posedge clock_i); #2;
      reset_i = 1'b1;
      @(negedge clock_i);
      n_checks++;
      if (write_o !== 1'b1 || read_o !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_word4: got write=%b read=%b expected 1/0010", write_o, read_o);
      end
      @(posedge clock_i); #2;
      reset_i = 1'b0;
      push_words(0, 2);
      @(negedge clock_i);
      n_checks++;
      if ({grant_o, grant_id_o, read_o, write_o, busy_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_outputs: got grant=%b id=%0d read=%b write=%b busy=%b expected all 0",
                  grant_o, grant_id_o, read_o, write_o, busy_o);
      end
      @(negedge clock_i);
      n_checks++;
      if (grant_o !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_first_grant: got %b expected 0001", grant_o);
      end
      drain("rst");
   endtask

   task automatic test_late_request();
      int wcnt, cyc;
      bit seen;
      do_reset();
      @(posedge clock_i); #2;
      push_words(1, 40);
      wcnt = 0; cyc = 0;
      while (wcnt < 2 && cyc < 20) begin
         @(negedge clock_i);
         cyc++;
         if (write_o === 1'b1) wcnt++;
      end
      @(posedge clock_i); #2;
      push_words(3, 3);
      seen = 1'b0; cyc = 0;
      while (!seen && cyc < 20) begin
         @(negedge clock_i);
         cyc++;
         if (grant_o === 4'b1000) seen = 1'b1;
      end
      n_checks++;
      if (!seen || cyc > 10) begin
         n_fail++;
         $display("FAIL late_grant: src3 granted=%b after %0d cycles, required within 10", seen, cyc);
      end
      drain("late");
   endtask

   // Global time bound in case a scenario stalls.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1;
      full_i  = 1'b0;
      for (int k = 0; k < N; k++) begin
         push_cnt[k] = 0;
         exp_seq[k]  = 0;
      end
      refresh();
      test_reset();
      test_single_source();
      test_back_to_back();
      test_backpressure();
      test_rotation();
      test_reset_mid_burst();
      test_late_request();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
